// File: rtl/cacheline_part_nru_pkg.sv
// Shared types and width helpers for the way-partitioned NRU cache set.
package cacheline_part_nru_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cacheline_part_nru_if.sv
// Config, flush and request/response bundle of the partitioned NRU cache set.
interface cacheline_part_nru_if
  import cacheline_part_nru_pkg::*;
#(
  parameter int NUM_WAYS    = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_DOMAINS = 4,
  parameter int WAY_W       = min1_clog2(NUM_WAYS),
  parameter int DOM_W       = min1_clog2(NUM_DOMAINS)
);
  logic                  cfg_valid;
  logic [DOM_W-1:0]      cfg_domain;
  logic [NUM_WAYS-1:0]   cfg_mask;
  logic                  flush_req;
  logic [DOM_W-1:0]      flush_domain;
  logic                  busy;
  logic                  req_valid;
  logic                  req_ready;
  logic [DOM_W-1:0]      req_domain;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [WAY_W-1:0]      resp_way;
  logic                  resp_fill;
  logic                  resp_evict;
  logic [ADDR_WIDTH-1:0] resp_evict_tag;

  modport master (
    output cfg_valid, cfg_domain, cfg_mask, flush_req, flush_domain,
           req_valid, req_domain, req_addr,
    input  busy, req_ready, resp_valid, resp_hit, resp_way, resp_fill,
           resp_evict, resp_evict_tag
  );

  modport slave (
    input  cfg_valid, cfg_domain, cfg_mask, flush_req, flush_domain,
           req_valid, req_domain, req_addr,
    output busy, req_ready, resp_valid, resp_hit, resp_way, resp_fill,
           resp_evict, resp_evict_tag
  );
endinterface

// File: rtl/cacheline_part_nru_victim_sel.sv
// Combinational NRU victim picker confined to a way mask:
// free way first, then a not-recently-used way, then the lowest owned way.
module cacheline_part_nru_victim_sel
  import cacheline_part_nru_pkg::*;
#(
  parameter int NUM_WAYS = 8,
  parameter int WAY_W    = min1_clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] mask_i,
  input  logic [NUM_WAYS-1:0] valid_i,
  input  logic [NUM_WAYS-1:0] nru_i,
  output logic [WAY_W-1:0]    victim_o,
  output logic                found_o,
  output logic                all_used_o
);
  logic [2:0][NUM_WAYS-1:0] cand, first;
  logic [2:0][WAY_W-1:0]    idx;

  assign cand[0] = mask_i & ~valid_i;
  assign cand[1] = mask_i & ~nru_i;
  assign cand[2] = mask_i;

  // One-hot lowest set bit of each candidate vector.
  for (genvar c = 0; c < 3; c++) begin : g_cand
    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
      if (i == 0) begin : g_lsb
        assign first[c][i] = cand[c][i];
      end else begin : g_rest
        assign first[c][i] = cand[c][i] & ~(|cand[c][i-1:0]);
      end
    end
  end

  always_comb begin
    idx = '0;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < NUM_WAYS; i++)
        if (first[c][i]) idx[c] = idx[c] | WAY_W'(i);
  end

  assign found_o    = |mask_i;
  assign all_used_o = found_o && !(|cand[0]) && !(|cand[1]);
  assign victim_o   = (|cand[0]) ? idx[0] : (|cand[1]) ? idx[1] : idx[2];

endmodule

// File: rtl/cacheline_part_nru.sv
// One cache set with NRU replacement, way-partitioned across security domains,
// plus a per-domain flush that walks one way per cycle.
module cacheline_part_nru
  import cacheline_part_nru_pkg::*;
#(
  parameter int NUM_WAYS    = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_DOMAINS = 4
) (
  input logic clk,
  input logic reset,
  cacheline_part_nru_if.slave bus
`ifdef INVARIANTS
  ,
  output logic [NUM_WAYS-1:0]             nru_o,
  output logic [NUM_WAYS-1:0]             valid_o,
  output logic [NUM_WAYS*ADDR_WIDTH-1:0]  tags_o,
  output logic [NUM_DOMAINS*NUM_WAYS-1:0] masks_o
`endif
);
  localparam int WAY_W = min1_clog2(NUM_WAYS);
  localparam int DOM_W = min1_clog2(NUM_DOMAINS);

  state_e                               state_q, state_d;
  logic [WAY_W-1:0]                     ptr_q, ptr_d;
  logic [NUM_WAYS-1:0]                  fmask_q, fmask_d;
  logic [NUM_WAYS-1:0]                  valid_q, valid_d, nru_q, nru_d;
  logic [NUM_WAYS-1:0][ADDR_WIDTH-1:0]  tags_q, tags_d;
  logic [NUM_DOMAINS-1:0][NUM_WAYS-1:0] masks_q;

  logic                  rvalid_q, rvalid_d, rhit_q, rhit_d;
  logic                  rfill_q, rfill_d, revict_q, revict_d;
  logic [WAY_W-1:0]      rway_q, rway_d;
  logic [ADDR_WIDTH-1:0] rtag_q, rtag_d;

  logic [NUM_WAYS-1:0] req_mask, flush_mask, hit_vec;
  logic                hit, accept, vfound, vall;
  logic [WAY_W-1:0]    hit_way, vic;

  // Domain lookup by compare so out-of-range domain ids see an empty mask.
  always_comb begin
    req_mask   = '0;
    flush_mask = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      if (DOM_W'(d) == bus.req_domain)   req_mask   = masks_q[d];
      if (DOM_W'(d) == bus.flush_domain) flush_mask = masks_q[d];
    end
  end

  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_hit
    assign hit_vec[i] = valid_q[i] && req_mask[i] && (tags_q[i] == bus.req_addr);
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (hit_vec[i]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
  end

  cacheline_part_nru_victim_sel #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_victim_sel (
    .mask_i     (req_mask),
    .valid_i    (valid_q),
    .nru_i      (nru_q),
    .victim_o   (vic),
    .found_o    (vfound),
    .all_used_o (vall)
  );

  assign bus.req_ready = (state_q == ST_IDLE) && !bus.flush_req;
  assign bus.busy      = (state_q == ST_FLUSH);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    fmask_d  = fmask_q;
    valid_d  = valid_q;
    nru_d    = nru_q;
    tags_d   = tags_q;
    rvalid_d = 1'b0;
    rhit_d   = 1'b0;
    rfill_d  = 1'b0;
    revict_d = 1'b0;
    rway_d   = '0;
    rtag_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d = ST_FLUSH;
          ptr_d   = '0;
          fmask_d = flush_mask;
        end else if (accept) begin
          rvalid_d = 1'b1;
          if (hit) begin
            rhit_d         = 1'b1;
            rway_d         = hit_way;
            nru_d[hit_way] = 1'b1;
          end else if (vfound) begin
            // Every owned way recently used: start a new NRU epoch for this domain.
            if (vall) nru_d = nru_q & ~req_mask;
            nru_d[vic]   = 1'b1;
            valid_d[vic] = 1'b1;
            tags_d[vic]  = bus.req_addr;
            rfill_d      = 1'b1;
            rway_d       = vic;
            revict_d     = valid_q[vic];
            rtag_d       = tags_q[vic];
          end
        end
      end
      ST_FLUSH: begin
        if (fmask_q[ptr_q]) begin
          valid_d[ptr_q] = 1'b0;
          nru_d[ptr_q]   = 1'b0;
          tags_d[ptr_q]  = '0;
        end
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == WAY_W'(NUM_WAYS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      fmask_q  <= '0;
      valid_q  <= '0;
      nru_q    <= '0;
      tags_q   <= '0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
      rfill_q  <= 1'b0;
      revict_q <= 1'b0;
      rway_q   <= '0;
      rtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      fmask_q  <= fmask_d;
      valid_q  <= valid_d;
      nru_q    <= nru_d;
      tags_q   <= tags_d;
      rvalid_q <= rvalid_d;
      rhit_q   <= rhit_d;
      rfill_q  <= rfill_d;
      revict_q <= revict_d;
      rway_q   <= rway_d;
      rtag_q   <= rtag_d;
    end
  end

  // Mask writes are independent of the FSM; a same-cycle request sees the old mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      masks_q <= '0;
    end else if (bus.cfg_valid) begin
      for (int d = 0; d < NUM_DOMAINS; d++)
        if (DOM_W'(d) == bus.cfg_domain) masks_q[d] <= bus.cfg_mask;
    end
  end

  assign bus.resp_valid     = rvalid_q;
  assign bus.resp_hit       = rhit_q;
  assign bus.resp_way       = rway_q;
  assign bus.resp_fill      = rfill_q;
  assign bus.resp_evict     = revict_q;
  assign bus.resp_evict_tag = rtag_q;

`ifdef INVARIANTS
  assign nru_o   = nru_q;
  assign valid_o = valid_q;
  assign tags_o  = tags_q;
  assign masks_o = masks_q;
`endif

endmodule
